// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake on both sides.
// MULLO is computed iteratively, MUL_BITS multiplier bits per cycle.
module alu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int SW    = $clog2(WIDTH);
    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [3:0] OP_ROL   = 4'hB;
    localparam logic [3:0] OP_MULLO = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, drain, is_mul;
    logic [SW-1:0]    shamt, rot_amt;
    logic [SW:0]      rot_inv;
    logic [WIDTH-1:0] rot, alu_res;
    logic [WIDTH-1:0] part_in, part, acc_nxt;

    assign shamt  = b_i[SW-1:0];
    assign is_mul = (op_i == OP_MULLO);
    assign accept = valid_i & ready_o;
    assign drain  = valid_o & ready_i;

    // A left rotate by s is a right rotate by (WIDTH - s) mod WIDTH
    assign rot_amt = (op_i == OP_ROL) ? (SW'(0) - shamt) : shamt;
    assign rot_inv = (SW+1)'(WIDTH) - {1'b0, rot_amt};
    assign rot     = (a_i >> rot_amt) | (a_i << rot_inv);

    always_comb begin
        alu_res = '0;
        case (op_i)
            4'h0: alu_res = a_i + b_i;
            4'h1: alu_res = a_i - b_i;
            4'h2: alu_res = a_i << shamt;
            4'h3: alu_res = $signed(a_i) >>> shamt;
            4'h4: alu_res = a_i >> shamt;
            4'h5: alu_res = a_i & b_i;
            4'h6: alu_res = a_i | b_i;
            4'h7: alu_res = ~(a_i | b_i);
            4'h8: alu_res = a_i ^ b_i;
            4'h9: alu_res = WIDTH'($signed(a_i) < $signed(b_i));
            4'hA: alu_res = WIDTH'(a_i < b_i);
            4'hB: alu_res = rot;
            4'hC: alu_res = rot;
            4'hE: alu_res = b_i;
            4'hF: alu_res = a_i;
            default: alu_res = '0;
        endcase
    end

    // First partial product is folded into the accept edge to hit WIDTH/MUL_BITS latency
    assign part_in = a_i * WIDTH'(b_i[MUL_BITS-1:0]);
    assign part    = mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]);
    assign acc_nxt = acc_q + part;

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (accept)
                    state_d = (is_mul && STEPS > 1) ? BUSY : FULL;
            end
            BUSY: begin
                if (cnt_q == CW'(1))
                    state_d = FULL;
            end
            FULL: begin
                valid_o = 1'b1;
                ready_o = ready_i;
                if (accept)
                    state_d = (is_mul && STEPS > 1) ? BUSY : FULL;
                else if (drain)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_o <= '0;
            zero_o   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (is_mul) begin
                    acc_q    <= part_in;
                    mcand_q  <= a_i << MUL_BITS;
                    mplier_q <= b_i >> MUL_BITS;
                    cnt_q    <= CW'(STEPS - 1);
                    if (STEPS == 1) begin
                        result_o <= part_in;
                        zero_o   <= (part_in == '0);
                    end
                end else begin
                    result_o <= alu_res;
                    zero_o   <= (alu_res == '0);
                end
            end else if (state_q == BUSY) begin
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_q << MUL_BITS;
                mplier_q <= mplier_q >> MUL_BITS;
                cnt_q    <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_o <= acc_nxt;
                    zero_o   <= (acc_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and short random checks of alu_pipe at WIDTH=32, MUL_BITS=4.
// Expected values come from hand-computed constants and a small reference model.
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_i, ready_o, ready_i, valid_o, zero_o;
    logic [3:0]   op_i;
    logic [W-1:0] a_i, b_i, result_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] e;
    logic         seen;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .MUL_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int s;
        logic [W-1:0] r;
        s = int'(b[4:0]);
        r = a;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a << s;
            4'h3: for (int k = 0; k < s; k++) r = {r[W-1], r[W-1:1]};
            4'h4: r = a >> s;
            4'h5: r = a & b;
            4'h6: r = a | b;
            4'h7: r = ~(a | b);
            4'h8: r = a ^ b;
            4'h9: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'hA: r = (a < b) ? 1 : 0;
            4'hB: for (int k = 0; k < s; k++) r = {r[W-2:0], r[W-1]};
            4'hC: for (int k = 0; k < s; k++) r = {r[0], r[W-1:1]};
            4'hD: r = a * b;
            4'hE: r = b;
            default: r = a;
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input logic z);
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
        #1;
        chk({tag, "_rdy"}, ready_o, 1);
        tick();
        valid_i = 1'b0;
        op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
        chk({tag, "_vld"}, valid_o, 1);
        chk(tag, result_o, exp);
        chk({tag, "_z"}, zero_o, z);
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
        op_i = 4'hD; a_i = a; b_i = b; valid_i = 1'b1;
        #1;
        chk({tag, "_rdy"}, ready_o, 1);
        tick();
        op_i = 4'h0; a_i = 32'd5; b_i = 32'd6;
        for (int i = 1; i < 8; i++) begin
            valid_i = (i % 2) == 1;
            #1;
            chk({tag, "_busy_rdy"}, ready_o, 0);
            chk({tag, "_busy_vld"}, valid_o, 0);
            tick();
        end
        valid_i = 1'b0;
        chk({tag, "_vld"}, valid_o, 1);
        chk(tag, result_o, exp);
        tick();
        chk({tag, "_drained"}, valid_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
        op_i = 4'h0; a_i = 32'd9; b_i = 32'd9;
        tick();
        tick();
        reset = 1'b0; valid_i = 1'b0;
        #1;
        chk("rst_vld", valid_o, 0);
        chk("rst_res", result_o, 0);
        chk("rst_zero", zero_o, 0);
        chk("rst_rdy", ready_o, 1);

        run_op("subu", 4'h1, 32'h0, 32'h1, 32'hFFFF_FFFF, 0);
        run_op("srav", 4'h3, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
        run_op("ror1", 4'hC, 32'h1, 32'd1, 32'h8000_0000, 0);
        run_op("rol0", 4'hB, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
        run_op("rol4", 4'hB, 32'h8000_0001, 32'd4, 32'h0000_0018, 0);
        run_op("ror8", 4'hC, 32'h1234_5678, 32'd8, 32'h7812_3456, 0);
        run_op("slt", 4'h9, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
        run_op("sltu", 4'hA, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("sllv", 4'h2, 32'h1, 32'h21, 32'h2, 0);
        run_op("srlv", 4'h4, 32'h8000_0000, 32'h1F, 32'h1, 0);
        run_op("addu", 4'h0, 32'hFFFF_FFFF, 32'h2, 32'h1, 0);
        run_op("and", 4'h5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0);
        run_op("or", 4'h6, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 0);
        run_op("nor", 4'h7, 32'h0, 32'h0, 32'hFFFF_FFFF, 0);
        run_op("xor", 4'h8, 32'hF0F0, 32'hFF00, 32'h0FF0, 0);
        run_op("mov", 4'hE, 32'h1111, 32'hABCD, 32'hABCD, 0);
        run_op("pass", 4'hF, 32'h5A5A, 32'hABCD, 32'h5A5A, 0);
        tick();
        chk("sweep_drained", valid_o, 0);

        run_mul("mul1", 32'd12345, 32'd6789, 32'h04FE_D79D);
        run_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);

        ready_i = 1'b0;
        run_op("bp_add", 4'h0, 32'd3, 32'd4, 32'd7, 0);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; op_i = 4'hF; a_i = 32'hDEAD;
            #1;
            chk("bp_rdy", ready_o, 0);
            chk("bp_vld", valid_o, 1);
            chk("bp_res", result_o, 7);
            tick();
        end
        ready_i = 1'b1;
        run_op("bp_next", 4'h0, 32'd1, 32'd1, 32'd2, 0);
        tick();
        chk("bp_drained", valid_o, 0);

        op_i = 4'hD; a_i = 32'd7; b_i = 32'd9; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmul_vld", valid_o, 0);
        chk("rmul_rdy", ready_o, 1);
        chk("rmul_res", result_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | valid_o;
            tick();
        end
        chk("rmul_never", seen, 0);

        for (int n = 0; n < 300; n++) begin
            valid_i = $urandom_range(0, 3) != 0;
            ready_i = $urandom_range(0, 3) != 0;
            op_i = 4'($urandom);
            a_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            b_i = $urandom;
            #1;
            if (valid_o && ready_i) begin
                chk("rnd_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rnd_res", result_o, e);
                    chk("rnd_zero", zero_o, e == '0);
                end
            end
            if (valid_i && ready_o)
                q.push_back(ref_alu(op_i, a_i, b_i));
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (valid_o && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_tail", result_o, e);
            end
            tick();
        end
        chk("rnd_left", q.size(), 0);
        chk("rnd_idle", valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
